// File: rtl/dkong_dma_mc.sv
// dkong_dma_mc: multi-channel fixed-priority block DMA. It holds the Z80 bus
// through BUSRQ/BUSAK and copies source RAM to destination RAM through a
// two-stage read/write pipeline.
// Optional constant-fill mode: define DKONG_DMA_FILL_EN.
module dkong_dma_mc #(
   parameter int CHANNELS = 2,
   parameter int AW       = 10,
   parameter int DW       = 8,
   parameter int LW       = 10
) (
   input  logic                   I_CLK,
   input  logic                   I_RESETn,
   input  logic                   I_CLK_EN,
   input  logic [CHANNELS-1:0]    I_DMA_TRIG,
   input  logic [CHANNELS*AW-1:0] I_CH_SRC,
   input  logic [CHANNELS*AW-1:0] I_CH_DST,
   input  logic [CHANNELS*LW-1:0] I_CH_LEN,
`ifdef DKONG_DMA_FILL_EN
   input  logic [CHANNELS-1:0]    I_CH_FILL,
   input  logic [DW-1:0]          I_FILL_D,
`endif
   input  logic                   I_HLDA,
   input  logic [DW-1:0]          I_DMA_DS,
   output logic                   O_HRQ,
   output logic [AW-1:0]          O_DMA_AS,
   output logic                   O_DMA_CES,
   output logic [AW-1:0]          O_DMA_AD,
   output logic [DW-1:0]          O_DMA_DD,
   output logic                   O_DMA_CED,
   output logic                   O_BUSY,
   output logic [1:0]             O_ACT_CH,
   output logic [CHANNELS-1:0]    O_DONE
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

   state_t              state, state_n;
   logic [CHANNELS-1:0] pending, trig_d, clr_mask;
   logic [1:0]          cur_ch, win_ch;
   logic [AW-1:0]       src_q, dst_q, win_src, win_dst;
   logic [LW-1:0]       len_q, rd_idx, wr_idx, win_len;
   logic                rd_vld, win_vld;
   logic                load, rewind, rd_go, wr_go;
`ifdef DKONG_DMA_FILL_EN
   logic                fill_q, win_fill;
`endif

   // Lowest-index pending channel wins arbitration
   always_comb begin
      win_vld  = 1'b0;
      win_ch   = '0;
      win_src  = '0;
      win_dst  = '0;
      win_len  = '0;
`ifdef DKONG_DMA_FILL_EN
      win_fill = 1'b0;
`endif
      for (int unsigned i = CHANNELS; i > 0; i--) begin
         if (pending[i-1]) begin
            win_vld  = 1'b1;
            win_ch   = 2'(i - 1);
            win_src  = I_CH_SRC[(i-1)*AW +: AW];
            win_dst  = I_CH_DST[(i-1)*AW +: AW];
            win_len  = I_CH_LEN[(i-1)*LW +: LW];
`ifdef DKONG_DMA_FILL_EN
            win_fill = I_CH_FILL[i-1];
`endif
         end
      end
   end

   // State register
   always_ff @(posedge I_CLK or negedge I_RESETn) begin
      if (!I_RESETn)
         state <= S_IDLE;
      else if (I_CLK_EN)
         state <= state_n;
   end

   // Next state, bus handshake, pipeline addressing and completion pulse
   always_comb begin
      state_n  = state;
      load     = 1'b0;
      rewind   = 1'b0;
      rd_go    = 1'b0;
      wr_go    = 1'b0;
      O_HRQ    = 1'b0;
      O_DMA_AS = '0;
      O_DMA_AD = '0;
      O_DMA_DD = '0;
      O_DONE   = '0;
      case (state)
         S_IDLE: begin
            if (win_vld) begin
               load    = 1'b1;
               state_n = (win_len == '0) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            O_HRQ = 1'b1;
            if (I_HLDA)
               state_n = S_XFER;
         end
         S_XFER: begin
            O_HRQ = 1'b1;
            if (!I_HLDA) begin
               rewind  = 1'b1;
               state_n = S_REQ;
            end else begin
               rd_go    = (rd_idx < len_q);
               wr_go    = rd_vld;
               O_DMA_AS = src_q + AW'(rd_idx);
               O_DMA_AD = dst_q + AW'(wr_idx);
               O_DMA_DD = I_DMA_DS;
`ifdef DKONG_DMA_FILL_EN
               if (fill_q) begin
                  rd_go    = 1'b0;
                  wr_go    = 1'b1;
                  O_DMA_AS = '0;
                  O_DMA_DD = I_FILL_D;
               end
`endif
               if (wr_go && (wr_idx + LW'(1) == len_q))
                  state_n = S_DONE;
            end
         end
         S_DONE: begin
            O_DONE  = CHANNELS'(1) << cur_ch;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign O_DMA_CES = rd_go & I_CLK_EN;
   assign O_DMA_CED = wr_go & I_CLK_EN;
   assign O_BUSY    = (state != S_IDLE);
   assign O_ACT_CH  = cur_ch;
   assign clr_mask  = load ? (CHANNELS'(1) << win_ch) : '0;

   // Trigger edge detection; a fresh edge re-arms a channel even while it is served
   always_ff @(posedge I_CLK or negedge I_RESETn) begin
      if (!I_RESETn) begin
         trig_d  <= '0;
         pending <= '0;
      end else if (I_CLK_EN) begin
         trig_d  <= I_DMA_TRIG;
         pending <= (pending & ~clr_mask) | (I_DMA_TRIG & ~trig_d);
      end
   end

   // Transfer context latch and read/write index pipeline
   always_ff @(posedge I_CLK or negedge I_RESETn) begin
      if (!I_RESETn) begin
         cur_ch <= '0;
         src_q  <= '0;
         dst_q  <= '0;
         len_q  <= '0;
         rd_idx <= '0;
         wr_idx <= '0;
         rd_vld <= 1'b0;
`ifdef DKONG_DMA_FILL_EN
         fill_q <= 1'b0;
`endif
      end else if (I_CLK_EN) begin
         if (load) begin
            cur_ch <= win_ch;
            src_q  <= win_src;
            dst_q  <= win_dst;
            len_q  <= win_len;
            rd_idx <= '0;
            wr_idx <= '0;
            rd_vld <= 1'b0;
`ifdef DKONG_DMA_FILL_EN
            fill_q <= win_fill;
`endif
         end else if (rewind) begin
            // the in-flight read is dropped and re-issued from the first unwritten index
            rd_idx <= wr_idx;
            rd_vld <= 1'b0;
         end else begin
            if (rd_go)
               rd_idx <= rd_idx + LW'(1);
            if (wr_go)
               wr_idx <= wr_idx + LW'(1);
            rd_vld <= rd_go;
         end
      end
   end

endmodule

// File: tb/tb_dkong_dma_mc.sv
// tb_dkong_dma_mc: directed vector table plus hand-written sequences for
// arbitration, re-trigger, bus-grant loss and mid-transfer reset.
module tb_dkong_dma_mc;
   localparam int CH = 2;
   localparam int AW = 10;
   localparam int DW = 8;
   localparam int LW = 10;
   localparam int SW = CH * AW;
   localparam int NW = CH * LW;

   typedef struct {
      int ch; int src; int dst; int len; int lat;
      int exp_rd; int exp_wr; int exp_hrq; int exp_busy;
      int exp_first_as; int exp_last_as; int exp_last_ad; int exp_wspan;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [1:0]     cnt = '0;
   logic           en;
   logic [CH-1:0]  I_DMA_TRIG;
   logic [SW-1:0]  I_CH_SRC, I_CH_DST;
   logic [NW-1:0]  I_CH_LEN;
   logic           I_HLDA;
   logic [DW-1:0]  I_DMA_DS;
   logic           O_HRQ, O_DMA_CES, O_DMA_CED, O_BUSY;
   logic [AW-1:0]  O_DMA_AS, O_DMA_AD;
   logic [DW-1:0]  O_DMA_DD;
   logic [1:0]     O_ACT_CH;
   logic [CH-1:0]  O_DONE;

   logic [7:0] smem [1024];
   logic [7:0] dmem [1024];
   int         hits [1024];

   int n_checks = 0, n_err = 0, stray = 0, strobe_nohlda = 0;
   int tick_no, n_hrq, n_hrq_rise, n_busy, n_rd, n_wr, n_done;
   int first_as, last_as, first_wt, last_wt, last_ad, dup, hrq_done_ovl;
   int hrq_run, lat_cfg, hlda_low_left, drop_at_wr;
   logic          hrq_prev;
   logic [CH-1:0] trig_drv, done_seen;
   bit            scramble_en;
   int            act_q [$];
   int            wr_q [$];

   dkong_dma_mc #(.CHANNELS(CH), .AW(AW), .DW(DW), .LW(LW)) dut (
      .I_CLK(clk), .I_RESETn(rst_n), .I_CLK_EN(en), .I_DMA_TRIG(I_DMA_TRIG),
      .I_CH_SRC(I_CH_SRC), .I_CH_DST(I_CH_DST), .I_CH_LEN(I_CH_LEN),
`ifdef DKONG_DMA_FILL_EN
      .I_CH_FILL('0), .I_FILL_D('0),
`endif
      .I_HLDA(I_HLDA), .I_DMA_DS(I_DMA_DS), .O_HRQ(O_HRQ), .O_DMA_AS(O_DMA_AS),
      .O_DMA_CES(O_DMA_CES), .O_DMA_AD(O_DMA_AD), .O_DMA_DD(O_DMA_DD),
      .O_DMA_CED(O_DMA_CED), .O_BUSY(O_BUSY), .O_ACT_CH(O_ACT_CH), .O_DONE(O_DONE)
   );

   always #5 clk = ~clk;

   // enable high one clock in three; changes on negedge so it is stable across posedge
   always @(negedge clk) cnt <= (cnt == 2'd2) ? 2'd0 : cnt + 2'd1;
   assign en = (cnt == 2'd0);

   // synchronous source RAM
   always @(posedge clk) if (en && O_DMA_CES) I_DMA_DS <= smem[O_DMA_AS];

   // strobes must never appear on disabled cycles
   always @(negedge clk) begin
      #3;
      if (!en && rst_n && (O_DMA_CES || O_DMA_CED)) stray++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [7:0] src_val(int a);
      return 8'(a) + 8'hA1;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic clear_stats();
      tick_no = 0; n_hrq = 0; n_hrq_rise = 0; n_busy = 0; n_rd = 0; n_wr = 0; n_done = 0;
      first_as = -1; last_as = -1; first_wt = -1; last_wt = -1; last_ad = -1;
      dup = 0; hrq_done_ovl = 0; hrq_run = 0; hlda_low_left = 0; drop_at_wr = 0;
      hrq_prev = 1'b0; done_seen = '0;
      act_q.delete();
      wr_q.delete();
      for (int i = 0; i < 1024; i++) begin
         hits[i] = 0;
         dmem[i] = 8'hEE;
      end
   endtask

   // one enabled tick: drive inputs, then sample outputs before the active edge
   task automatic step_tick();
      do begin @(negedge clk); #1; end while (!en);
      I_DMA_TRIG = trig_drv;
      if (hlda_low_left > 0) begin
         I_HLDA = 1'b0;
         hlda_low_left--;
      end else
         I_HLDA = (hrq_run >= lat_cfg);
      #2;
      tick_no++;
      if (O_HRQ && !hrq_prev) n_hrq_rise++;
      hrq_prev = O_HRQ;
      if (O_HRQ) begin hrq_run++; n_hrq++; end else hrq_run = 0;
      if (O_BUSY) begin
         n_busy++;
         if (act_q.size() == 0 || act_q[$] != int'(O_ACT_CH)) act_q.push_back(int'(O_ACT_CH));
      end
      if ((O_DMA_CES || O_DMA_CED) && !I_HLDA) strobe_nohlda++;
      if (O_DMA_CES) begin
         n_rd++;
         if (first_as < 0) first_as = int'(O_DMA_AS);
         last_as = int'(O_DMA_AS);
      end
      if (O_DMA_CED) begin
         n_wr++;
         if (first_wt < 0) first_wt = tick_no;
         last_wt = tick_no;
         last_ad = int'(O_DMA_AD);
         wr_q.push_back(int'(O_DMA_AD));
         if (hits[O_DMA_AD] != 0) dup++;
         hits[O_DMA_AD]++;
         dmem[O_DMA_AD] = O_DMA_DD;
         if (drop_at_wr != 0 && n_wr == drop_at_wr) hlda_low_left = 5;
      end
      if (O_DONE != '0) begin
         n_done++;
         done_seen |= O_DONE;
         if (O_HRQ) hrq_done_ovl++;
      end
      if (scramble_en && O_HRQ) begin
         I_CH_SRC = SW'($urandom);
         I_CH_DST = SW'($urandom);
         I_CH_LEN = NW'($urandom);
      end
   endtask

   task automatic wait_done(input int target);
      int k = 0;
      while (!(n_done >= target && !O_BUSY) && k < 200) begin
         step_tick();
         k++;
      end
      chk("wait_done_timeout", int'(k >= 200), 0);
   endtask

   task automatic wait_wr(input int target);
      int k = 0;
      while (n_wr < target && k < 200) begin
         step_tick();
         k++;
      end
      chk("wait_wr_timeout", int'(k >= 200), 0);
   endtask

   task automatic set_ch(input int ch, input int src, input int dst, input int len);
      I_CH_SRC[ch*AW +: AW] = AW'(src);
      I_CH_DST[ch*AW +: AW] = AW'(dst);
      I_CH_LEN[ch*LW +: LW] = LW'(len);
   endtask

   task automatic fire(input logic [CH-1:0] mask);
      trig_drv = mask;
      step_tick();
      trig_drv = '0;
   endtask

   task automatic chk_data(input string nm, input int src, input int dst, input int len);
      int bad = 0;
      for (int i = 0; i < len; i++)
         if (dmem[(dst + i) % 1024] !== src_val((src + i) % 1024)) bad++;
      chk(nm, bad, 0);
   endtask

   initial begin
      vec_t vt [5];
      //       ch  src    dst    len lat rd wr hrq busy first  last   lastad span
      vt[0] = '{0, 'h100, 'h000, 3,  2,  3, 3, 7,  8,   'h100, 'h102, 'h002, 2};
      vt[1] = '{1, 'h3FE, 'h050, 4,  0,  4, 4, 6,  7,   'h3FE, 'h001, 'h053, 3};
      vt[2] = '{0, 'h010, 'h020, 0,  1,  0, 0, 0,  1,   -1,    -1,    -1,    0};
      vt[3] = '{1, 'h200, 'h3FD, 5,  1,  5, 5, 8,  9,   'h200, 'h204, 'h001, 4};
      vt[4] = '{0, 'h0F0, 'h180, 1,  3,  1, 1, 6,  7,   'h0F0, 'h0F0, 'h180, 0};

      for (int i = 0; i < 1024; i++) smem[i] = src_val(i);
      rst_n = 1'b0; I_DMA_TRIG = '0; I_CH_SRC = '0; I_CH_DST = '0; I_CH_LEN = '0;
      I_HLDA = 1'b0; trig_drv = '0; scramble_en = 1'b0; lat_cfg = 0;
      clear_stats();

      #20;
      chk("rst_hrq", O_HRQ, 0);
      chk("rst_ces", O_DMA_CES, 0);
      chk("rst_ced", O_DMA_CED, 0);
      chk("rst_busy", O_BUSY, 0);
      chk("rst_act", O_ACT_CH, 0);
      chk("rst_done", O_DONE, 0);
      chk("rst_as", O_DMA_AS, 0);
      chk("rst_ad", O_DMA_AD, 0);
      #13 rst_n = 1'b1;
      step_tick();
      chk("idle_busy", O_BUSY, 0);
      chk("idle_hrq", O_HRQ, 0);

      for (int i = 0; i < 5; i++) begin
         vec_t v;
         v = vt[i];
         clear_stats();
         lat_cfg = v.lat;
         set_ch(v.ch, v.src, v.dst, v.len);
         fire(CH'(1) << v.ch);
         scramble_en = 1'b1;
         wait_done(1);
         scramble_en = 1'b0;
         chk($sformatf("v%0d_reads", i), n_rd, v.exp_rd);
         chk($sformatf("v%0d_writes", i), n_wr, v.exp_wr);
         chk($sformatf("v%0d_hrq_ticks", i), n_hrq, v.exp_hrq);
         chk($sformatf("v%0d_busy_ticks", i), n_busy, v.exp_busy);
         chk($sformatf("v%0d_first_as", i), first_as, v.exp_first_as);
         chk($sformatf("v%0d_last_as", i), last_as, v.exp_last_as);
         chk($sformatf("v%0d_last_ad", i), last_ad, v.exp_last_ad);
         chk($sformatf("v%0d_wr_span", i), last_wt - first_wt, v.exp_wspan);
         chk($sformatf("v%0d_done_cnt", i), n_done, 1);
         chk($sformatf("v%0d_done_mask", i), done_seen, 1 << v.ch);
         chk($sformatf("v%0d_hrq_in_done", i), hrq_done_ovl, 0);
         chk($sformatf("v%0d_act_ch", i), (act_q.size() == 1) ? act_q[0] : -1, v.ch);
         chk_data($sformatf("v%0d_data", i), v.src, v.dst, v.len);
      end

      // both channels on the same tick: channel 0 runs to completion first
      clear_stats();
      lat_cfg = 1;
      set_ch(0, 'h000, 'h300, 2);
      set_ch(1, 'h040, 'h340, 2);
      fire(2'b11);
      wait_done(2);
      chk("prio_done_cnt", n_done, 2);
      chk("prio_done_mask", done_seen, 3);
      chk("prio_act_len", act_q.size(), 2);
      chk("prio_act_first", (act_q.size() > 0) ? act_q[0] : -1, 0);
      chk("prio_act_second", (act_q.size() > 1) ? act_q[1] : -1, 1);
      chk("prio_hrq_rises", n_hrq_rise, 2);
      chk("prio_writes", n_wr, 4);
      chk("prio_hrq_in_done", hrq_done_ovl, 0);
      chk_data("prio_data_ch0", 'h000, 'h300, 2);
      chk_data("prio_data_ch1", 'h040, 'h340, 2);

      // re-trigger of the active channel queues a second run
      clear_stats();
      lat_cfg = 0;
      set_ch(0, 'h020, 'h100, 2);
      fire(2'b01);
      wait_wr(1);
      fire(2'b01);
      wait_done(2);
      chk("rerun_done_cnt", n_done, 2);
      chk("rerun_writes", n_wr, 4);
      chk("rerun_hrq_rises", n_hrq_rise, 2);
      chk("rerun_act_len", act_q.size(), 1);
      chk_data("rerun_data", 'h020, 'h100, 2);

      // bus grant withdrawn for five ticks after the second write
      clear_stats();
      lat_cfg = 0;
      set_ch(0, 'h080, 'h200, 8);
      drop_at_wr = 2;
      fire(2'b01);
      wait_done(1);
      drop_at_wr = 0;
      chk("hold_writes", n_wr, 8);
      chk("hold_reads", n_rd, 9);
      chk("hold_dup", dup, 0);
      chk("hold_resume_ad", (wr_q.size() > 2) ? wr_q[2] : -1, 'h202);
      chk("hold_hrq_ticks", n_hrq, 17);
      chk("hold_hrq_rises", n_hrq_rise, 1);
      chk("hold_done_cnt", n_done, 1);
      chk_data("hold_data", 'h080, 'h200, 8);

      // asynchronous reset in the middle of a transfer with channel 1 pending
      clear_stats();
      lat_cfg = 0;
      set_ch(0, 'h000, 'h080, 8);
      set_ch(1, 'h010, 'h0C0, 3);
      fire(2'b01);
      wait_wr(1);
      fire(2'b10);
      wait_wr(3);
      chk("pre_rst_ced", O_DMA_CED, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_hrq", O_HRQ, 0);
      chk("mid_rst_ces", O_DMA_CES, 0);
      chk("mid_rst_ced", O_DMA_CED, 0);
      chk("mid_rst_busy", O_BUSY, 0);
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b1;
      clear_stats();
      repeat (10) step_tick();
      chk("post_rst_busy", n_busy, 0);
      chk("post_rst_hrq", n_hrq, 0);
      chk("post_rst_strobes", n_rd + n_wr, 0);
      chk("post_rst_act", O_ACT_CH, 0);

      chk("strobe_without_hlda", strobe_nohlda, 0);
      chk("strobe_off_enable", stray, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/dkong_dma_mc.md
Name: dkong_dma_mc

Overview:
Parametrised multi-channel successor to the single sprite DMA. It copies blocks from a synchronous source RAM (read port) to a destination RAM (write port) while holding the CPU bus via the Z80 BUSRQ/BUSAK handshake. Each channel has its own source base, destination base, length and trigger, and requests are served by fixed priority. It sits between the CPU work RAM B-port and the object/line RAM A-port, clocked from the 24.576 MHz master clock with a 3.072 MHz enable.

Parameters:
CHANNELS, 2, number of independent DMA channels (1..4)
AW, 10, source/destination address width
DW, 8, data width
LW, 10, transfer-length counter width

Ports:
I_CLK  in  1  master clock (24.576 MHz)
I_RESETn  in  1  asynchronous active-low reset
I_CLK_EN  in  1  transfer-rate enable; all state advances only when high
I_DMA_TRIG  in  CHANNELS  per-channel trigger, rising-edge sensitive
I_CH_SRC  in  CHANNELS*AW  per-channel source base, channel n at [n*AW +: AW]
I_CH_DST  in  CHANNELS*AW  per-channel destination base
I_CH_LEN  in  CHANNELS*LW  per-channel byte count; 0 = empty transfer
I_HLDA  in  1  bus grant (active-high, from ~BUSAK_n)
I_DMA_DS  in  DW  source RAM read data, valid one enabled tick after O_DMA_AS/O_DMA_CES
O_HRQ  out  1  bus request (active-high, drives ~BUSRQ_n)
O_DMA_AS  out  AW  source address
O_DMA_CES  out  1  source read enable
O_DMA_AD  out  AW  destination address
O_DMA_DD  out  DW  destination write data
O_DMA_CED  out  1  destination write strobe
O_BUSY  out  1  high from leaving IDLE until return to IDLE
O_ACT_CH  out  2  index of the channel being served
O_DONE  out  CHANNELS  one-enabled-tick pulse per completed channel

Behaviour:
- Reset (async, I_RESETn=0): all outputs 0, FSM=IDLE, pending bits cleared, trigger edge registers cleared. I_CLK_EN ignored while in reset.
- Edge detection: on each enabled tick, TRIG & ~TRIG_d sets pending[n]. A trigger arriving while channel n is active sets pending[n] again, so the channel re-runs after it completes.
- Arbitration: in IDLE, the lowest-index pending channel wins. Its base addresses and length are latched, its pending bit is cleared, and the FSM goes to REQ. Later base/length changes do not affect a running transfer.
- LEN=0: FSM goes IDLE -> DONE directly, with no HRQ, no strobes, and an O_DONE pulse.
- REQ: O_HRQ=1 and the FSM waits for I_HLDA=1 on an enabled tick, then goes to XFER.
- XFER: two-stage pipeline; tick k reads source index k, tick k+1 writes destination index k.
  - O_DMA_AS = src+rd_idx, O_DMA_CES=1 while rd_idx<LEN.
  - O_DMA_CED=1, O_DMA_AD = dst+wr_idx, O_DMA_DD = I_DMA_DS when a read was issued on the previous tick.
  - A transfer of L bytes occupies L+1 enabled ticks.
  - Address arithmetic is modulo 2^AW (base+index wraps).
- After the last write, the FSM goes to DONE: O_HRQ drops, O_DONE[ch] pulses for one enabled tick, then IDLE. O_HRQ stays high for the whole transfer.
- HLDA lost mid-XFER (sampled 0 on an enabled tick):
  - No strobes are driven on that tick.
  - The outstanding read is discarded: rd_idx is rewound to wr_idx.
  - FSM returns to REQ with O_HRQ held high, and resumes without loss or duplication of bytes.
- Strobes O_DMA_CES and O_DMA_CED are combinationally qualified by I_CLK_EN, giving exactly one strobe per enabled tick.
- Between enabled ticks all registered outputs hold.

Optional Feature:
- Macro: DKONG_DMA_FILL_EN.
- When defined, two extra inputs exist: I_CH_FILL (CHANNELS bits) and I_FILL_D (DW bits).
- A channel with I_CH_FILL[n]=1 issues no source reads (O_DMA_CES=0). It writes I_FILL_D to dst..dst+LEN-1 on consecutive enabled ticks, so L bytes take L ticks.
- When undefined, those ports and the fill logic are absent, and every channel is copy-only.

Test Plan:
- Channel 0: SRC=0x100, DST=0x000, LEN=3, source holds 0xA1,0xA2,0xA3; trigger 0->1 with HLDA returned 2 ticks after HRQ -> HRQ rises, then CED writes 0x000=A1, 0x001=A2, 0x002=A3 on 3 consecutive ticks, O_DONE[0] pulses once, and HRQ stays high through the transfer and drops when the FSM enters DONE.
- Channels 0 and 1 triggered on the same tick -> channel 0 fully completes first; channel 1 then issues a fresh HRQ; O_ACT_CH reads 0 then 1.
- LEN=0 trigger -> O_DONE pulse, O_HRQ never asserted, no CES/CED.
- SRC=0x3FE, LEN=4 with AW=10 -> source addresses 0x3FE, 0x3FF, 0x000, 0x001.
- HLDA dropped for 5 ticks after the 2nd write of an 8-byte transfer -> writes pause, resume at index 2, and all 8 destination bytes are correct with no duplicate strobes.
- Assert I_RESETn=0 mid-XFER -> HRQ, CES and CED go 0 immediately; after release the FSM is IDLE and pending bits are clear.
